// File: rtl/iteration_sequencer_if.sv
// Control/handshake bundle between the gradient-descent sequencer,
// the master, the xy-data process and the theta datapaths.
interface iteration_sequencer_if #(
  parameter int ITER_W = 16
);
  logic              start;
  logic              avg_valid_in;
  logic              conv_flag_in;
  logic              abort;
  logic              out_ready;
  logic              xy_valid_out;
  logic              en_theta;
  logic [1:0]        sel_theta;
  logic              output_valid;
  logic [ITER_W-1:0] iter_cnt;
  logic              timeout;
  logic              busy;

  modport master (
    output start, avg_valid_in, conv_flag_in,
    output abort, out_ready,
    input  xy_valid_out, en_theta, sel_theta,
    input  output_valid, iter_cnt, timeout, busy
  );

  modport slave (
    input  start, avg_valid_in, conv_flag_in,
    input  abort, out_ready,
    output xy_valid_out, en_theta, sel_theta,
    output output_valid, iter_cnt, timeout, busy
  );
endinterface

// File: rtl/iteration_sequencer.sv
// Gradient-descent iteration controller: init, fixed-length calc
// phases, theta updates, convergence/limit exit and result handshake.
module iteration_sequencer #(
  parameter int CAL_CYCLES = 10,
  parameter int MAX_ITER   = 1000,
  parameter int CONV_HOLD  = 2,
  parameter int ITER_W     = 16
) (
  input logic                 clk,
  input logic                 rst,
  iteration_sequencer_if.slave sq
);
  localparam int CR_W = $clog2(CONV_HOLD + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_INIT,
    S_CAL,
    S_UPD,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [15:0]       cal_cnt;
  logic [CR_W-1:0]   conv_run;
  logic [CR_W-1:0]   conv_d;
  logic [ITER_W-1:0] iter_d;
  logic              cal_last;
  logic              conv_hit;
  logic              iter_hit;
  logic              kill;

  assign cal_last = cal_cnt == 16'(CAL_CYCLES - 1);
  assign iter_d   = sq.iter_cnt + ITER_W'(1);
  assign conv_hit = conv_d == CR_W'(CONV_HOLD);
  assign iter_hit = iter_d == ITER_W'(MAX_ITER);
  assign kill     = sq.abort && state != S_IDLE;

  // Saturating run of consecutive converged updates.
  always_comb begin
    conv_d = '0;
    if (sq.conv_flag_in)
      conv_d = (conv_run == CR_W'(CONV_HOLD)) ?
               conv_run : conv_run + CR_W'(1);
  end

  always_comb begin
    state_d = state;
    if (kill) begin
      state_d = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (sq.start) state_d = S_WAIT;
        S_WAIT: if (sq.avg_valid_in) state_d = S_INIT;
        S_INIT: state_d = S_CAL;
        S_CAL:  if (cal_last) state_d = S_UPD;
        S_UPD:  state_d = (conv_hit || iter_hit) ? S_DONE : S_CAL;
        S_DONE: if (sq.out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they stay Moore-clean.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cal_cnt         <= '0;
      conv_run        <= '0;
      sq.iter_cnt     <= '0;
      sq.timeout      <= 1'b0;
      sq.busy         <= 1'b0;
      sq.en_theta     <= 1'b0;
      sq.sel_theta    <= 2'd2;
      sq.output_valid <= 1'b0;
      sq.xy_valid_out <= 1'b0;
    end else begin
      state           <= state_d;
      sq.busy         <= state_d != S_IDLE;
      sq.output_valid <= state_d == S_DONE;
      sq.en_theta     <= state_d == S_INIT || state_d == S_UPD;
      sq.xy_valid_out <= state == S_IDLE && sq.start;
      unique case (1'b1)
        state_d == S_WAIT,
        state_d == S_INIT: sq.sel_theta <= 2'd0;
        state_d == S_CAL,
        state_d == S_UPD:  sq.sel_theta <= 2'd1;
        default:           sq.sel_theta <= 2'd2;
      endcase
      if (state == S_CAL && state_d == S_CAL)
        cal_cnt <= cal_cnt + 16'd1;
      else
        cal_cnt <= '0;
      if (kill) begin
        conv_run <= '0;
      end else if (state == S_IDLE && sq.start) begin
        conv_run    <= '0;
        sq.iter_cnt <= '0;
        sq.timeout  <= 1'b0;
      end else if (state == S_UPD) begin
        conv_run    <= conv_d;
        sq.iter_cnt <= iter_d;
        sq.timeout  <= iter_hit && !conv_hit;
      end
    end
  end
endmodule

// File: tb/tb_iteration_sequencer.sv
// Bench for iteration_sequencer: vector table, directed corners and
// randomized runs checked against a run-level timing model.
module tb_iteration_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic avg = 1'b0;
  logic conv = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iteration_sequencer_if #(.ITER_W(16)) if0 ();
  iteration_sequencer_if #(.ITER_W(16)) if1 ();

  assign if0.start = start;
  assign if0.avg_valid_in = avg;
  assign if0.conv_flag_in = conv;
  assign if0.abort = abort;
  assign if0.out_ready = ready;
  assign if1.start = start;
  assign if1.avg_valid_in = avg;
  assign if1.conv_flag_in = conv;
  assign if1.abort = abort;
  assign if1.out_ready = ready;

  iteration_sequencer #(
    .CAL_CYCLES(10), .MAX_ITER(1000),
    .CONV_HOLD(2), .ITER_W(16)
  ) u0 (.clk(clk), .rst(rst), .sq(if0.slave));

  iteration_sequencer #(
    .CAL_CYCLES(1), .MAX_ITER(3),
    .CONV_HOLD(1), .ITER_W(16)
  ) u1 (.clk(clk), .rst(rst), .sq(if1.slave));

  // Observed DUT: {busy, en_theta, sel_theta, output_valid, xy_valid_out}
  logic [5:0]  obs;
  logic [15:0] o_iter;
  logic        o_to;
  assign obs = sel ?
    {if1.busy, if1.en_theta, if1.sel_theta, if1.output_valid, if1.xy_valid_out} :
    {if0.busy, if0.en_theta, if0.sel_theta, if0.output_valid, if0.xy_valid_out};
  assign o_iter = sel ? if1.iter_cnt : if0.iter_cnt;
  assign o_to   = sel ? if1.timeout : if0.timeout;

  function automatic int cfg_c();
    return sel ? 1 : 10;
  endfunction
  function automatic int cfg_m();
    return sel ? 3 : 1000;
  endfunction
  function automatic int cfg_h();
    return sel ? 1 : 2;
  endfunction

  // Convergence flag presented on update j (1-based); all ones past bit 31.
  function automatic logic patbit(input logic [31:0] pat, input int j);
    logic [31:0] p;
    p = pat;
    return (j <= 32) ? p[j-1] : 1'b1;
  endfunction

  // Number of updates until exit and whether the exit was the limit.
  function automatic void model(input logic [31:0] pat, input int m,
                                input int h, output int k, output bit to);
    int run;
    run = 0;
    k = m;
    to = 1'b1;
    for (int j = 1; j <= m; j++) begin
      run = patbit(pat, j) ? run + 1 : 0;
      if (run >= h) begin
        k = j;
        to = 1'b0;
        return;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic a, input logic cv,
                      input logic ab, input logic rd);
    start = s;
    avg = a;
    conv = cv;
    abort = ab;
    ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  // One full run: start at edge 0, avg at edge d+1, out_ready held low r
  // cycles in DONE. Inputs that should be ignored are randomized.
  task automatic run_seq(input int d, input int r, input logic [31:0] pat,
                         input string tag);
    int k;
    bit to;
    int cc;
    int t_init;
    int t_done;
    model(pat, cfg_m(), cfg_h(), k, to);
    cc = cfg_c() + 1;
    t_init = d + 1;
    t_done = t_init + k * cc + 1;
    do_reset();
    for (int c = 0; c <= t_done + r + 1; c++) begin
      int rel;
      logic e_en;
      logic e_ov;
      logic e_busy;
      logic e_xy;
      logic [1:0] e_sel;
      start = (c == 0) ? 1'b1 : ($urandom_range(7) == 0);
      avg = (c == d + 1) ? 1'b1 :
            (c > d + 1) ? 1'($urandom_range(1)) : 1'b0;
      rel = c - 1 - t_init;
      if (c >= 1 && rel > 0 && rel % cc == 0 && rel / cc <= k)
        conv = patbit(pat, rel / cc);
      else
        conv = 1'($urandom_range(1));
      ready = (c == t_done + r + 1) ? 1'b1 :
              (c > t_done) ? 1'b0 : 1'($urandom_range(1));
      abort = 1'b0;
      @(posedge clk);
      #1;
      rel = c - t_init;
      e_en = rel >= 0 && rel % cc == 0 && rel / cc <= k;
      e_sel = (c <= t_init) ? 2'd0 : (c < t_done) ? 2'd1 : 2'd2;
      e_ov = c >= t_done && c <= t_done + r;
      e_busy = c <= t_done + r;
      e_xy = c == 0;
      chk($sformatf("%s c%0d", tag, c), 32'(obs),
          32'({e_busy, e_en, e_sel, e_ov, e_xy}));
    end
    start = 1'b0;
    chk({tag, " iter"}, 32'(o_iter), 32'(k));
    chk({tag, " timeout"}, 32'(o_to), 32'(to));
    step(0, 1, 1, 0, 1);
    chk({tag, " hold"}, {o_iter, 15'd0, o_to}, {16'(k), 15'd0, to});
  endtask

  typedef struct {
    logic [5:0] in;
    logic [5:0] out;
    int         iter;
    bit         to;
  } vec_t;

  vec_t tv[14];

  initial begin
    // {rst,start,avg,conv,abort,ready} -> {busy,en,sel,ov,xy}
    tv[0]  = '{6'b100000, 6'b001000, 0, 0};
    tv[1]  = '{6'b010000, 6'b100001, 0, 0};
    tv[2]  = '{6'b000000, 6'b100000, 0, 0};
    tv[3]  = '{6'b001000, 6'b110000, 0, 0};
    tv[4]  = '{6'b000000, 6'b100100, 0, 0};
    tv[5]  = '{6'b000000, 6'b110100, 0, 0};
    tv[6]  = '{6'b000000, 6'b100100, 1, 0};
    tv[7]  = '{6'b000000, 6'b110100, 1, 0};
    tv[8]  = '{6'b000000, 6'b100100, 2, 0};
    tv[9]  = '{6'b000000, 6'b110100, 2, 0};
    tv[10] = '{6'b000100, 6'b101010, 3, 0};
    tv[11] = '{6'b000001, 6'b001000, 3, 0};
    tv[12] = '{6'b010010, 6'b100001, 0, 0};
    tv[13] = '{6'b000010, 6'b001000, 0, 0};

    sel = 1'b1;
    for (int i = 0; i < 14; i++) begin
      logic [5:0] v;
      v = tv[i].in;
      rst = v[5];
      step(v[4], v[3], v[2], v[1], v[0]);
      rst = 1'b0;
      chk($sformatf("vec%0d", i), {obs, o_iter, 9'd0, o_to},
          {tv[i].out, 16'(tv[i].iter), 9'd0, tv[i].to});
    end

    sel = 1'b0;
    run_seq(4, 7, 32'hFFFF_FFFC, "basic");
    run_seq(2, 3, 32'hFFFF_FFFD, "holdrst");
    sel = 1'b1;
    run_seq(1, 2, 32'h0000_0000, "timeout");
    run_seq(0, 0, 32'h0000_0004, "conv_at_limit");

    // Abort in the 4th CAL cycle of the second iteration.
    sel = 1'b0;
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    repeat (15) step(0, 0, 0, 0, 0);
    chk("pre_abort", {obs, o_iter}, {6'b100100, 16'd1});
    step(0, 0, 1, 1, 1);
    chk("abort", {obs, o_iter}, {6'b001000, 16'd1});
    step(0, 1, 0, 0, 0);
    chk("abort_idle", 32'(obs), 32'(6'b001000));

    // Reset while waiting for the average.
    step(1, 0, 0, 0, 0);
    chk("wait", 32'(obs), 32'(6'b100001));
    rst = 1'b1;
    step(0, 1, 0, 0, 0);
    rst = 1'b0;
    chk("rst_wait", {obs, o_iter, 9'd0, o_to}, {6'b001000, 16'd0, 9'd0, 1'b0});
    repeat (3) step(0, 1, 1, 0, 1);
    chk("rst_avg_ignored", 32'(obs), 32'(6'b001000));

    repeat (24) begin
      sel = 1'($urandom_range(1));
      run_seq(int'($urandom_range(6)), int'($urandom_range(5)),
              32'($urandom), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
